gray_codec_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-bit binary-to-Gray converter.
- Supports three modes on a WIDTH-bit bus:
  - binary->Gray conversion
  - Gray->binary conversion
  - free-running Gray sequence generation
- Valid/ready handshake on both sides, two-stage registered pipeline. Sits between counter/pointer logic and clock-domain-crossing or encoder paths.

---
 rtl/gray_codec_pipe.sv | 195 +++++++++++++++++++
 tb/tb_gray_codec_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_codec_pipe.sv
// -----------------------------------------------------------------------------
// gray_codec_pipe
//
// Purpose:
//   Two-stage valid/ready pipeline that converts binary to Gray and Gray to
//   binary. It can also emit a free-running Gray sequence taken from an
//   internal counter. Each beat carries its own mode through the pipe, so the
//   mode may change on every beat.
//
// Parameters:
//   WIDTH     data width in bits (2..32)
//   CNT_INIT  binary start value of the sequence counter after reset
//
// Ports:
//   Clk        rising-edge clock
//   Rst        asynchronous active-high reset
//   Mode       00 bin->Gray, 01 Gray->bin, 10 sequence, 11 reserved
//   In_valid   input beat valid
//   In_ready   block can accept a beat
//   Data_in    operand (ignored in mode 10)
//   Out_valid  result valid
//   Out_ready  downstream accepts result
//   Data_out   converted / generated code
//   Mode_err   result came from reserved mode 11
//   Step_err   (only with GRAY_STEP_CHECK_EN) a mode-01 input was not a
//              single-bit step from the previous mode-01 input
//
// Optional feature macro: GRAY_STEP_CHECK_EN
// -----------------------------------------------------------------------------
module gray_codec_pipe #(
  parameter int          WIDTH    = 8,
  parameter int unsigned CNT_INIT = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Mode,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] Data_in,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Data_out,
`ifdef GRAY_STEP_CHECK_EN
  output logic             Mode_err,
  output logic             Step_err
`else
  output logic             Mode_err
`endif
);

  localparam logic [1:0] MODE_B2G = 2'b00;
  localparam logic [1:0] MODE_G2B = 2'b01;
  localparam logic [1:0] MODE_SEQ = 2'b10;

  // Stage 1 state
  logic             s1_valid;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] s1_data;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_err;

  // Sequence counter
  logic [WIDTH-1:0] cnt;

  logic s1_load;
  logic s2_load;

  assign s2_load  = s1_valid && (!s2_valid || Out_ready);
  // In_ready depends only on stage state and Out_ready, never on In_valid.
  assign In_ready = !s1_valid || s2_load;
  assign s1_load  = In_valid && In_ready;

  // ---------------------------------------------------------------------------
  // Stage-2 arithmetic
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] g2b;

  assign b2g[WIDTH-1] = s1_data[WIDTH-1];
  assign g2b[WIDTH-1] = s1_data[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH-1; gi++) begin : g_bits
      assign b2g[gi] = s1_data[gi] ^ s1_data[gi+1];
      // Each binary bit is the XOR of all Gray bits at or above it. This is
      // written as a reduction so that there is no bit-to-bit chain on one
      // vector.
      assign g2b[gi] = ^s1_data[WIDTH-1:gi];
    end
  endgenerate

  logic [WIDTH-1:0] result;
  logic             result_err;

  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (s1_mode)
      MODE_B2G: result = b2g;
      MODE_G2B: result = g2b;
      // S1 already holds the pre-increment counter value for sequence beats.
      MODE_SEQ: result = b2g;
      default:  result_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional Gray step checker (evaluated at input acceptance)
  // ---------------------------------------------------------------------------
`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             prev_seen;
  logic [WIDTH-1:0] step_diff;
  logic             single_step;
  logic             step_flag;
  logic             s1_step;
  logic             s2_step;

  assign step_diff   = Data_in ^ prev_gray;
  assign single_step = (step_diff != '0) &&
                       ((step_diff & (step_diff - WIDTH'(1))) == '0);
  assign step_flag   = (Mode == MODE_G2B) && prev_seen && !single_step;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      prev_gray <= '0;
      prev_seen <= 1'b0;
      s1_step   <= 1'b0;
      s2_step   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_step <= step_flag;
        if (Mode == MODE_G2B) begin
          prev_gray <= Data_in;
          prev_seen <= 1'b1;
        end
      end
      if (s2_load) begin
        s2_step <= s1_step;
      end
    end
  end

  assign Step_err = s2_step;
`endif

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 2'b00;
      s1_data  <= '0;
      cnt      <= WIDTH'(CNT_INIT);
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_mode  <= Mode;
        // Sequence beats capture the counter here, so the counter value
        // follows input acceptance order even when the pipe stalls.
        s1_data  <= (Mode == MODE_SEQ) ? cnt : Data_in;
        if (Mode == MODE_SEQ) begin
          cnt <= cnt + WIDTH'(1);
        end
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_err   <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_data  <= result;
        s2_err   <= result_err;
      end else if (Out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign Out_valid = s2_valid;
  assign Data_out  = s2_data;
  assign Mode_err  = s2_err;

endmodule

// File: tb/tb_gray_codec_pipe.sv
module tb_gray_codec_pipe;

  logic Clk;
  logic Rst;

  // Instance a: WIDTH=4, CNT_INIT=14
  logic [1:0] a_mode;
  logic       a_in_valid;
  logic       a_in_ready;
  logic [3:0] a_din;
  logic       a_out_valid;
  logic       a_out_ready;
  logic [3:0] a_dout;
  logic       a_merr;

  // Instance b: WIDTH=8, CNT_INIT=0
  logic [1:0] b_mode;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_din;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [7:0] b_dout;
  logic       b_merr;

`ifdef GRAY_STEP_CHECK_EN
  logic a_step;
  logic b_step;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  gray_codec_pipe #(.WIDTH(4), .CNT_INIT(14)) dut_a (
    .Clk(Clk), .Rst(Rst), .Mode(a_mode), .In_valid(a_in_valid),
    .In_ready(a_in_ready), .Data_in(a_din), .Out_valid(a_out_valid),
    .Out_ready(a_out_ready), .Data_out(a_dout),
`ifdef GRAY_STEP_CHECK_EN
    .Mode_err(a_merr), .Step_err(a_step)
`else
    .Mode_err(a_merr)
`endif
  );

  gray_codec_pipe #(.WIDTH(8), .CNT_INIT(0)) dut_b (
    .Clk(Clk), .Rst(Rst), .Mode(b_mode), .In_valid(b_in_valid),
    .In_ready(b_in_ready), .Data_in(b_din), .Out_valid(b_out_valid),
    .Out_ready(b_out_ready), .Data_out(b_dout),
`ifdef GRAY_STEP_CHECK_EN
    .Mode_err(b_merr), .Step_err(b_step)
`else
    .Mode_err(b_merr)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] g_tab [16];

  initial begin
    g_tab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    Rst = 1'b1;
    a_mode = 2'b00; a_in_valid = 1'b0; a_din = '0; a_out_ready = 1'b1;
    b_mode = 2'b00; b_in_valid = 1'b0; b_din = '0; b_out_ready = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_dout",      32'(a_dout), 0);
    check("rst_merr",      32'(a_merr), 0);
    check("rst_in_ready",  32'(a_in_ready), 1);
    $display("reset: Out_valid=%0d Data_out=%0h In_ready=%0d", a_out_valid, a_dout, a_in_ready);

    // Sequence generation from CNT_INIT=14, wrapping through all-ones
    a_mode = 2'b10; a_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i >= 4) a_in_valid = 1'b0;
      tick();
      if (i == 1) begin check("seq0", 32'(a_dout), 32'h9); check("seq0_v", 32'(a_out_valid), 1); end
      if (i == 2) check("seq1", 32'(a_dout), 32'h8);
      if (i == 3) check("seq2", 32'(a_dout), 32'h0);
      if (i == 4) begin check("seq3", 32'(a_dout), 32'h1); check("seq3_merr", 32'(a_merr), 0); end
      if (i >= 1 && i <= 4) $display("seq beat %0d: Data_out=%b", i-1, a_dout);
    end
    tick();
    check("seq_idle_valid", 32'(a_out_valid), 0);

    // Binary -> Gray sweep at full throughput
    a_mode = 2'b00;
    for (int i = 0; i < 18; i++) begin
      a_in_valid = (i < 16);
      a_din = 4'(i);
      tick();
      if (i == 0) check("b2g_latency", 32'(a_out_valid), 0);
      if (i >= 1 && i <= 16) begin
        check("b2g_valid", 32'(a_out_valid), 1);
        check($sformatf("b2g_%0d", i-1), 32'(a_dout), 32'(g_tab[i-1]));
        $display("b2g in=%0d out=%0d", i-1, a_dout);
      end
    end
    check("b2g_drain", 32'(a_out_valid), 0);

    // Gray -> binary, WIDTH=8
    b_mode = 2'b01; b_in_valid = 1'b1;
    b_din = 8'hC0; tick();
    b_din = 8'h80; tick();
    check("g2b_C0", 32'(b_dout), 32'h80);
    $display("g2b in=C0 out=%h", b_dout);
`ifdef GRAY_STEP_CHECK_EN
    check("step_first", 32'(b_step), 0);
`endif
    b_din = 8'hFF; tick();
    check("g2b_80", 32'(b_dout), 32'hFF);
    $display("g2b in=80 out=%h", b_dout);
`ifdef GRAY_STEP_CHECK_EN
    check("step_one_bit", 32'(b_step), 0);
`endif
    b_in_valid = 1'b0; tick();
    check("g2b_FF", 32'(b_dout), 32'hAA);
    $display("g2b in=FF out=%h", b_dout);
`ifdef GRAY_STEP_CHECK_EN
    check("step_multi_bit", 32'(b_step), 1);
`endif
    tick();

    // Backpressure: three beats, Out_ready held low
    a_mode = 2'b00; a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_din = 4'd3; tick();
    check("bp_ready_after1", 32'(a_in_ready), 1);
    a_din = 4'd5; tick();
    a_din = 4'd9;
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready_low", 32'(a_in_ready), 0);
      check("bp_hold_valid", 32'(a_out_valid), 1);
      check("bp_hold_data", 32'(a_dout), 32'h2);
      $display("bp hold cycle %0d: Data_out=%0d In_ready=%0d", i, a_dout, a_in_ready);
      tick();
    end
    a_out_ready = 1'b1; #1;
    check("bp_release_ready", 32'(a_in_ready), 1);
    tick();
    a_in_valid = 1'b0;
    check("bp_beat1", 32'(a_dout), 32'h7);
    $display("bp out beat1 Data_out=%0d", a_dout);
    tick();
    check("bp_beat2", 32'(a_dout), 32'hD);
    check("bp_beat2_v", 32'(a_out_valid), 1);
    $display("bp out beat2 Data_out=%0d", a_dout);
    tick();
    check("bp_empty", 32'(a_out_valid), 0);

    // Reserved mode between two mode-00 beats
    a_in_valid = 1'b1;
    a_mode = 2'b00; a_din = 4'h5; tick();
    a_mode = 2'b11; a_din = 4'hA; tick();
    check("m11_pre_data", 32'(a_dout), 32'h7);
    check("m11_pre_err", 32'(a_merr), 0);
    a_mode = 2'b00; a_din = 4'h6; tick();
    a_in_valid = 1'b0;
    check("m11_data", 32'(a_dout), 32'h0);
    check("m11_err", 32'(a_merr), 1);
    $display("mode11 beat: Data_out=%0h Mode_err=%0d", a_dout, a_merr);
    tick();
    check("m11_post_data", 32'(a_dout), 32'h5);
    check("m11_post_err", 32'(a_merr), 0);
    tick();

    // Reset with two beats in flight (counter has advanced past CNT_INIT)
    a_mode = 2'b10; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick(); tick();
    a_in_valid = 1'b0;
    check("inflight_valid", 32'(a_out_valid), 1);
    Rst = 1'b1; #1;
    check("arst_valid", 32'(a_out_valid), 0);
    check("arst_data", 32'(a_dout), 0);
    check("arst_merr", 32'(a_merr), 0);
    tick();
    Rst = 1'b0; a_out_ready = 1'b1;
    tick();
    check("post_rst_ready", 32'(a_in_ready), 1);
    check("post_rst_valid", 32'(a_out_valid), 0);
    a_in_valid = 1'b1; tick();
    a_in_valid = 1'b0; tick();
    check("post_rst_seq", 32'(a_dout), 32'h9);
    check("post_rst_seq_v", 32'(a_out_valid), 1);
    $display("post reset seq: Data_out=%b", a_dout);
    tick();

`ifdef GRAY_STEP_CHECK_EN
    b_mode = 2'b01; b_in_valid = 1'b1;
    b_din = 8'h01; tick();
    b_din = 8'h02; tick();
    b_in_valid = 1'b0;
    check("step_after_rst_first", 32'(b_step), 0);
    tick();
    check("step_after_rst_second", 32'(b_step), 1);
    $display("step check 01->02: Step_err=%0d", b_step);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
